icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, log2 of line count; 64 direct-mapped lines of one 32-bit word each.
REQ-002 Parameter TAG_BITS, default 30-INDEX_BITS, tag width taken from fetch_addr[31:2+INDEX_BITS].
REQ-003 clk_in  input  1  single clock; all state updates on posedge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global run enable; low = pause.
REQ-006 clear_in  input  1  invalidate all lines (fence.i / program reload).
REQ-007 fetch_en  input  1  fetch request; held high with stable fetch_addr until inst_valid.
REQ-008 fetch_addr  input  32  instruction byte address; bits [1:0] ignored.
REQ-009 inst_valid  output  1  one-cycle pulse; inst_data valid.
REQ-010 inst_data  output  32  fetched instruction word.
REQ-011 mem_query_en  output  1  block request to memory controller.
REQ-012 mem_head_addr  output  32  word-aligned request address.
REQ-013 mem_block_en  input  1  one-cycle pulse; mem_block_data valid.
REQ-014 mem_block_data  input  32  returned word, little-endian byte order.

Function
REQ-015 Storage: valid[2^INDEX_BITS], tag[2^INDEX_BITS], data[2^INDEX_BITS]; index = fetch_addr[2+INDEX_BITS-1:2].
REQ-016 States: IDLE, MISS_WAIT, RESPOND; reset state IDLE.
REQ-017 rdy_in low: no state, array, or output register changes; pulses in flight are held, not dropped.
REQ-018 IDLE, fetch_en high, hit (valid & tag match): inst_valid=1 and inst_data=line data next cycle; stay IDLE; hit latency 1 cycle.
REQ-019 IDLE, fetch_en high, miss: next cycle mem_query_en=1, mem_head_addr={fetch_addr[31:2],2'b00}; latch index/tag; go MISS_WAIT.
REQ-020 MISS_WAIT: mem_query_en and mem_head_addr held stable until mem_block_en seen.
REQ-021 On mem_block_en in MISS_WAIT: mem_query_en=0 next cycle (controller waits exactly one cycle for drop); line written data/tag, valid=1; go RESPOND.
REQ-022 RESPOND: inst_valid=1, inst_data=filled word for one cycle; return IDLE; miss-to-inst_valid = 1 cycle after mem_block_en.
REQ-023 No new miss request while mem_query_en high or in the cycle after it drops; at most one outstanding request.
REQ-024 mem_block_en outside MISS_WAIT: ignored.
REQ-025 inst_valid never asserted two consecutive cycles for a single request; fetch_en low in IDLE: inst_valid=0.
REQ-026 clear_in in IDLE: all valid bits cleared next cycle; a simultaneous fetch_en is treated as miss.
REQ-027 clear_in in MISS_WAIT: valid bits cleared; request not cancelled; returned block filled, but inst_valid suppressed (return IDLE, not RESPOND).
REQ-028 clear_in in RESPOND: inst_valid suppressed; all valid bits cleared including just-filled line.
REQ-029 fetch_addr changes while MISS_WAIT: ignored; fill uses latched address.

Reset
REQ-030 rst_n_in low: immediately state=IDLE, all valid=0, inst_valid=0, inst_data=0, mem_query_en=0, mem_head_addr=0; data/tag arrays need not reset.
REQ-031 Reset mid-miss: request abandoned; after release, any stale mem_block_en is ignored (REQ-024).

Verification
REQ-032 Cold fetch 0x0000_0000, controller returns 0x0000_0513 after 5 cycles -> mem_query_en one cycle after fetch_en, mem_head_addr=0x0, inst_valid/inst_data=0x0000_0513 one cycle after mem_block_en.
REQ-033 Refetch 0x0000_0000 -> inst_valid next cycle, 0x0000_0513, no mem_query_en.
REQ-034 Fetch 0x0000_0100 (same index, different tag, INDEX_BITS=6) -> miss, head_addr 0x100; then 0x0 misses again.
REQ-035 clear_in asserted during MISS_WAIT for 0x0000_0004 -> no inst_valid, line filled; subsequent fetch 0x4 after clear -> hit only if clear preceded fill.
REQ-036 rdy_in low for 3 cycles around mem_block_en -> outputs frozen; inst_valid appears exactly one rdy-high cycle after fill.
REQ-037 rst_n_in low during MISS_WAIT -> mem_query_en=0 immediately; post-reset fetch 0x0 misses.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// master = CPU fetch unit plus memory controller, slave = the cache.
interface icache_if;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        mem_query_en;
    logic [31:0] mem_head_addr;
    logic        mem_block_en;
    logic [31:0] mem_block_data;

    modport master (
        output fetch_en, fetch_addr, mem_block_en, mem_block_data,
        input  inst_valid, inst_data, mem_query_en, mem_head_addr
    );

    modport slave (
        input  fetch_en, fetch_addr, mem_block_en, mem_block_data,
        output inst_valid, inst_data, mem_query_en, mem_head_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// miss. rdy_in freezes every register; clear_in invalidates all lines.
module icache #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic     clk_in,
    input  logic     rst_n_in,
    input  logic     rdy_in,
    input  logic     clear_in,
    icache_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS_WAIT, RESPOND} state_t;

    typedef struct packed {
        logic [INDEX_BITS-1:0] idx;
        logic [TAG_BITS-1:0]   tag;
    } miss_t;

    state_t              state, state_n;
    logic [LINES-1:0]    valid, valid_n;
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [31:0]         data_arr [LINES];
    miss_t               miss_q, miss_n;
    logic                clr_seen, clr_n;
    logic                hold_q, hold_n;
    logic                vld_q, vld_n;
    logic [31:0]         data_q, data_n;
    logic                query_q, query_n;
    logic [31:0]         head_q, head_n;
    logic                fill_we;

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  hit;
    logic                  unused_ok;

    assign f_idx     = bus.fetch_addr[2 +: INDEX_BITS];
    assign f_tag     = bus.fetch_addr[31 -: TAG_BITS];
    assign hit       = valid[f_idx] && (tag_arr[f_idx] == f_tag);
    assign unused_ok = &{1'b0, bus.fetch_addr[1:0]};

    always_comb begin
        state_n = state;
        valid_n = valid;
        miss_n  = miss_q;
        clr_n   = clr_seen;
        hold_n  = 1'b0;
        vld_n   = 1'b0;
        data_n  = data_q;
        query_n = query_q;
        head_n  = head_q;
        fill_we = 1'b0;
        case (state)
            IDLE: begin
                if (clear_in) valid_n = '0;
                // vld_q/hold_q block re-accepting the request whose response is on the bus
                // and a new miss in the cycle right after mem_query_en dropped
                if (bus.fetch_en && !vld_q && !hold_q) begin
                    if (hit && !clear_in) begin
                        vld_n  = 1'b1;
                        data_n = data_arr[f_idx];
                    end else begin
                        query_n = 1'b1;
                        head_n  = {bus.fetch_addr[31:2], 2'b00};
                        miss_n  = '{idx: f_idx, tag: f_tag};
                        clr_n   = 1'b0;
                        state_n = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                if (clear_in) begin
                    valid_n = '0;
                    clr_n   = 1'b1;
                end
                if (bus.mem_block_en) begin
                    query_n = 1'b0;
                    fill_we = 1'b1;
                    // a clear in the fill cycle itself also wipes the new line
                    valid_n[miss_q.idx] = ~clear_in;
                    if (clr_seen || clear_in) begin
                        state_n = IDLE;
                        hold_n  = 1'b1;
                    end else begin
                        state_n = RESPOND;
                        vld_n   = 1'b1;
                        data_n  = bus.mem_block_data;
                    end
                end
            end
            RESPOND: begin
                if (clear_in) valid_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid    <= '0;
            miss_q   <= '0;
            clr_seen <= 1'b0;
            hold_q   <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            query_q  <= 1'b0;
            head_q   <= '0;
        end else if (rdy_in) begin
            valid    <= valid_n;
            miss_q   <= miss_n;
            clr_seen <= clr_n;
            hold_q   <= hold_n;
            vld_q    <= vld_n;
            data_q   <= data_n;
            query_q  <= query_n;
            head_q   <= head_n;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            tag_arr[miss_q.idx]  <= miss_q.tag;
            data_arr[miss_q.idx] <= bus.mem_block_data;
        end
    end

    // clear_in during RESPOND withdraws the pulse in the same cycle
    assign bus.inst_valid    = vld_q && !(state == RESPOND && clear_in);
    assign bus.inst_data     = data_q;
    assign bus.mem_query_en  = query_q;
    assign bus.mem_head_addr = head_q;
endmodule

// File: tb/tb_icache.sv
// Scoreboarded bench for icache: directed corner cases, then randomized fetches
// against a line-residency model, with a latency-randomizing memory responder.
module tb_icache;
    logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, clear_in = 1'b0;

    icache_if bus();
    icache dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
                .clear_in(clear_in), .bus(bus.slave));

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] data;
        bit          miss;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0, n_bad = 0, resp_cnt = 0;
    bit          queried = 0, last_cons = 0, fill_expect_valid = 1;
    bit          rand_rdy = 0, lat_rand = 0, resp_busy = 0;
    int          lat = 1;
    logic [31:0] req_addr = '0;
    bit          res_v [64];
    logic [31:0] res_line [64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0) return 32'h0000_0513;
        return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF ^ (w << 7);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
    endtask

    // monitor: head address while a request is open, responses against the scoreboard
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            queried   = 1'b0;
            last_cons = 1'b0;
        end else begin
            if (bus.mem_query_en) begin
                queried = 1'b1;
                chk("head_addr", bus.mem_head_addr, {req_addr[31:2], 2'b00});
            end
            if (rdy_in) begin
                if (bus.inst_valid) begin
                    exp_t e;
                    chk("single_pulse", {31'b0, last_cons}, 32'h0);
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_inst_valid: got data %h, required no response", bus.inst_data);
                    end else begin
                        e = sb.pop_front();
                        chk("inst_data", bus.inst_data, e.data);
                        chk("miss_flag", {31'b0, queried}, {31'b0, e.miss});
                    end
                    queried = 1'b0;
                    resp_cnt++;
                end
                last_cons = bus.inst_valid;
            end
        end
    end

    // memory controller: one block per request, pulse held until a running edge takes it
    initial begin
        logic [31:0] addr;
        int          l;
        bit          taken;
        bus.mem_block_en   = 1'b0;
        bus.mem_block_data = '0;
        forever begin
            @(negedge clk_in iff (bus.mem_query_en === 1'b1));
            resp_busy = 1'b1;
            addr = bus.mem_head_addr;
            l = lat_rand ? $urandom_range(0, 4) : lat;
            repeat (l) @(posedge clk_in);
            @(posedge clk_in);
            #1;
            bus.mem_block_en   = 1'b1;
            bus.mem_block_data = mem_word(addr);
            do begin
                @(posedge clk_in);
                taken = rdy_in;
                #1;
            end while (!taken);
            bus.mem_block_en = 1'b0;
            chk("query_drop", {31'b0, bus.mem_query_en}, 32'h0);
            chk("fill_to_valid", {31'b0, bus.inst_valid}, {31'b0, fill_expect_valid});
            resp_busy = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (rand_rdy) rdy_in = ($urandom_range(0, 5) != 0);
        end
    end

    // issue one fetch at posedge+1 and hold it until the monitor sees its response
    task automatic do_fetch(input logic [31:0] a, input bit wiggle);
        exp_t e;
        int   idx, cnt;
        bit   hit, r;
        idx = int'((a >> 2) % 64);
        hit = res_v[idx] && (res_line[idx] == (a >> 2));
        e.data = mem_word(a);
        e.miss = !hit;
        sb.push_back(e);
        req_addr = a;
        cnt = resp_cnt;
        bus.fetch_addr = a;
        bus.fetch_en   = 1'b1;
        @(posedge clk_in);
        r = rdy_in;
        #1;
        if (r) begin
            chk("query_after_fetch", {31'b0, bus.mem_query_en}, {31'b0, !hit});
            chk("hit_latency", {31'b0, bus.inst_valid}, {31'b0, hit});
        end
        for (int t = 0; t < 500 && resp_cnt == cnt; t++) begin
            if (wiggle && bus.mem_query_en) bus.fetch_addr = $urandom;
            @(posedge clk_in);
            #1;
        end
        if (resp_cnt == cnt) begin
            n_vec++;
            n_bad++;
            $display("FAIL fetch_timeout: addr %h got no inst_valid, required one within 500 cycles", a);
        end
        bus.fetch_en = 1'b0;
        res_v[idx]    = 1'b1;
        res_line[idx] = a >> 2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bit          r;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        model_clear();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_query", {31'b0, bus.mem_query_en}, 32'h0);
        chk("rst_head", bus.mem_head_addr, 32'h0);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        lat = 5;  do_fetch(32'h0, 0);
        do_fetch(32'h0, 0);
        lat = 2;  do_fetch(32'h100, 0);
        do_fetch(32'h0, 0);

        // clear while the miss is outstanding: fill lands, response withheld, then hit
        lat = 6;
        fill_expect_valid = 0;
        fork
            do_fetch(32'h4, 0);
            begin
                @(posedge clk_in iff bus.mem_query_en);
                @(posedge clk_in);
                #2 clear_in = 1'b1;
                model_clear();
                @(posedge clk_in);
                #2 clear_in = 1'b0;
            end
        join
        fill_expect_valid = 1;
        do_fetch(32'h4, 0);
        do_fetch(32'h0, 0);

        // clear in the response cycle: pulse withdrawn, line refetched
        lat = 1;
        fork
            do_fetch(32'h10, 0);
            begin
                @(posedge clk_in iff bus.mem_block_en);
                #2 clear_in = 1'b1;
                model_clear();
                @(posedge clk_in);
                #2 clear_in = 1'b0;
            end
        join
        do_fetch(32'h10, 0);

        // clear together with a fetch that would hit
        clear_in = 1'b1;
        model_clear();
        fork
            do_fetch(32'h10, 0);
            begin
                @(posedge clk_in);
                #1 clear_in = 1'b0;
            end
        join

        // pause for three cycles right after the fill edge
        lat = 3;
        fork
            do_fetch(32'h20, 0);
            begin
                @(posedge clk_in iff bus.mem_block_en);
                #1 rdy_in = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_in);
                    chk("pause_valid_held", {31'b0, bus.inst_valid}, 32'h1);
                    chk("pause_data_held", bus.inst_data, mem_word(32'h20));
                    chk("pause_query_low", {31'b0, bus.mem_query_en}, 32'h0);
                end
                @(posedge clk_in);
                #1 rdy_in = 1'b1;
                @(negedge clk_in);
                chk("resume_valid", {31'b0, bus.inst_valid}, 32'h1);
            end
        join

        lat = 4;  do_fetch(32'h8, 1);

        // reset in the middle of a miss; the late block must be ignored
        lat = 20;
        fill_expect_valid = 0;
        req_addr       = 32'h44;
        bus.fetch_addr = 32'h44;
        bus.fetch_en   = 1'b1;
        @(posedge clk_in iff bus.mem_query_en);
        @(posedge clk_in);
        #3 rst_n_in = 1'b0;
        #1;
        chk("midrst_query", {31'b0, bus.mem_query_en}, 32'h0);
        chk("midrst_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("midrst_head", bus.mem_head_addr, 32'h0);
        bus.fetch_en = 1'b0;
        model_clear();
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        for (int t = 0; t < 100 && resp_busy; t++) @(posedge clk_in);
        if (resp_busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL stale_block_timeout: responder still busy, required idle");
        end
        @(posedge clk_in);
        #1;
        chk("stale_ignored", {31'b0, bus.mem_query_en}, 32'h0);
        fill_expect_valid = 1;
        lat = 2;
        do_fetch(32'h0, 0);

        rand_rdy = 1;
        lat_rand = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                clear_in = 1'b1;
                do begin
                    @(posedge clk_in);
                    r = rdy_in;
                    #1;
                end while (!r);
                clear_in = 1'b0;
                model_clear();
            end
            a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            do_fetch(a, $urandom_range(0, 3) == 0);
        end
        rand_rdy = 0;
        @(posedge clk_in);
        #1 rdy_in = 1'b1;
        repeat (5) @(posedge clk_in);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL leftover_expected: %0d responses outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
